// File: rtl/factor_pkg.sv
// Shared constants and state encoding for the sequential factor search.
// The divider and the sequencing FSM both size their datapaths from here.
package factor_pkg;

    localparam int W_T          = 12;
    localparam int W_F          = 6;
    localparam int D_MIN        = 2;
    localparam int D_MAX        = 63;
    localparam int CYC_PER_CAND = 14;
    localparam int W_CNT        = $clog2(W_T + 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        DIV   = 3'd2,
        CHECK = 3'd3,
        DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/factor_div_serial.sv
// Serial restoring divider: one quotient bit per cycle, W_T cycles after load.
// The divisor must be held stable from load until valid rises.
module factor_div_serial
    import factor_pkg::*;
(
    input  logic           clk,
    input  logic           rst_n,
    input  logic           load,
    input  logic [W_T-1:0] dividend,
    input  logic [W_F-1:0] divisor,
    output logic [W_F:0]   rem,
    output logic [W_T-1:0] quo,
    output logic           valid
);

    logic [W_F:0]     r_rem;
    logic [W_T-1:0]   r_quo;
    logic [W_CNT-1:0] r_cnt;
    logic             r_run;

    logic [W_F:0]     w_rem_sh;
    logic [W_F:0]     w_div_ext;
    logic [W_F:0]     w_rem_nx;
    logic             w_ge;

    // The partial remainder stays below the divisor, so its low W_F bits
    // plus the incoming dividend bit always fit in W_F+1 bits.
    always_comb begin
        w_rem_sh  = {r_rem[W_F-1:0], r_quo[W_T-1]};
        w_div_ext = {1'b0, divisor};
        w_ge      = (w_rem_sh >= w_div_ext);
        w_rem_nx  = w_ge ? (w_rem_sh - w_div_ext) : w_rem_sh;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rem <= '0;
            r_quo <= '0;
            r_cnt <= '0;
            r_run <= 1'b0;
        end else if (load) begin
            r_rem <= '0;
            r_quo <= dividend;
            r_cnt <= '0;
            r_run <= 1'b1;
        end else if (r_run) begin
            r_rem <= w_rem_nx;
            r_quo <= {r_quo[W_T-2:0], w_ge};
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == W_CNT'(W_T - 1)) begin
                r_run <= 1'b0;
            end
        end
    end

    assign rem   = r_rem;
    assign quo   = r_quo;
    assign valid = !r_run && (r_cnt == W_CNT'(W_T));

endmodule

// File: rtl/factor_search.sv
// Finds the factor pair (f1,f2) of a W_T-bit target with the smallest f1,
// both factors in [D_MIN, D_MAX], by trial division over every candidate.
module factor_search
    import factor_pkg::*;
(
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [W_T-1:0] target,
    output logic           busy,
    output logic           done,
    output logic           found,
    output logic [W_F-1:0] f1,
    output logic [W_F-1:0] f2,
    output logic [2:0]     o_dbg_state
);

    state_t           r_state;
    state_t           w_next;

    logic [W_T-1:0]   r_t_q;
    logic [W_F-1:0]   r_d;
    logic [W_CNT-1:0] r_cnt;
    logic             r_found;
    logic [W_F-1:0]   r_f1;
    logic [W_F-1:0]   r_f2;

    logic             w_load;
    logic             w_hit;
    logic             w_last_d;
    logic [W_F:0]     w_rem;
    logic [W_T-1:0]   w_quo;
    logic             w_valid;

    factor_div_serial u_div (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (w_load),
        .dividend (r_t_q),
        .divisor  (r_d),
        .rem      (w_rem),
        .quo      (w_quo),
        .valid    (w_valid)
    );

    // A cofactor outside [D_MIN, D_MAX] would not fit the checker's factor
    // width, so such exact divisions are rejected and the sweep continues.
    always_comb begin
        w_hit    = w_valid && (w_rem == '0)
                   && (w_quo >= W_T'(D_MIN)) && (w_quo <= W_T'(D_MAX));
        w_last_d = (r_d == W_F'(D_MAX));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        w_load = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_next = LOAD;
                end
            end
            LOAD: begin
                w_load = 1'b1;
                w_next = DIV;
            end
            DIV: begin
                if (r_cnt == W_CNT'(W_T - 1)) begin
                    w_next = CHECK;
                end
            end
            CHECK: begin
                if (w_hit || w_last_d) begin
                    w_next = DONE;
                end else begin
                    w_next = LOAD;
                end
            end
            DONE: begin
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // Result registers are cleared on acceptance so that a search in flight
    // never shows a stale pair from the previous target.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_t_q   <= '0;
            r_d     <= '0;
            r_cnt   <= '0;
            r_found <= 1'b0;
            r_f1    <= '0;
            r_f2    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_t_q   <= target;
                        r_d     <= W_F'(D_MIN);
                        r_found <= 1'b0;
                        r_f1    <= '0;
                        r_f2    <= '0;
                    end
                end
                LOAD: begin
                    r_cnt <= '0;
                end
                DIV: begin
                    r_cnt <= r_cnt + 1'b1;
                end
                CHECK: begin
                    if (w_hit) begin
                        r_found <= 1'b1;
                        r_f1    <= r_d;
                        r_f2    <= w_quo[W_F-1:0];
                    end else if (!w_last_d) begin
                        r_d <= r_d + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign busy        = (r_state != IDLE);
    assign done        = (r_state == DONE);
    assign found       = r_found;
    assign f1          = r_f1;
    assign f2          = r_f2;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_factor_search.sv
// Self-checking bench for factor_search: a reference model predicts every
// result and its timing; directed jobs also carry hand-computed literals.
module tb_factor_search;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [11:0] target;
    logic        busy;
    logic        done;
    logic        found;
    logic [5:0]  f1;
    logic [5:0]  f2;
    logic [2:0]  dbg_state;

    int checks   = 0;
    int failures = 0;

    int edge_cnt    = 0;
    int accept_edge = 0;
    bit job_active  = 0;

    bit exp_found;
    int exp_f1;
    int exp_f2;
    int exp_lat;
    int exp_t;

    int held_found = 0;
    int held_f1    = 0;
    int held_f2    = 0;

    factor_search dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .target      (target),
        .busy        (busy),
        .done        (done),
        .found       (found),
        .f1          (f1),
        .f2          (f2),
        .o_dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    // ---------------- reference model ----------------
    // Smallest d in [2,63] dividing t with cofactor in [2,63]; every rejected
    // candidate costs 14 cycles and the result shows one cycle later.
    function automatic void model(input int t, output bit fnd, output int a,
                                  output int b, output int lat);
        fnd = 0;
        a   = 0;
        b   = 0;
        lat = 14 * 62 + 1;
        for (int d = 2; d <= 63; d++) begin
            if (!fnd && (t % d == 0) && (t / d >= 2) && (t / d <= 63)) begin
                fnd = 1;
                a   = d;
                b   = t / d;
                lat = 14 * (d - 1) + 1;
            end
        end
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            if (failures <= 40)
                $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- compare process ----------------
    initial begin : compare
        int p;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                chk("rst_busy", busy, 0);
                chk("rst_done", done, 0);
                chk("rst_found", found, 0);
                chk("rst_f1", f1, 0);
                chk("rst_f2", f2, 0);
                held_found = 0;
                held_f1    = 0;
                held_f2    = 0;
            end else if (job_active) begin
                p = edge_cnt - accept_edge + 1;
                chk("busy", busy, (p <= exp_lat) ? 1 : 0);
                chk("done", done, (p == exp_lat) ? 1 : 0);
                if (p == exp_lat) begin
                    chk("found", found, exp_found);
                    chk("f1", f1, exp_f1);
                    chk("f2", f2, exp_f2);
                    if (found === 1'b1) begin
                        chk("pair_formula",
                            ((int'(f1) * int'(f2) == exp_t) && f1 >= 2 && f2 >= 2) ? 1 : 0, 1);
                    end
                    held_found = exp_found;
                    held_f1    = exp_f1;
                    held_f2    = exp_f2;
                end else if (p < exp_lat) begin
                    chk("run_found", found, 0);
                    chk("run_f1", f1, 0);
                    chk("run_f2", f2, 0);
                end
            end else begin
                chk("idle_busy", busy, 0);
                chk("idle_done", done, 0);
                chk("hold_found", found, held_found);
                chk("hold_f1", f1, held_f1);
                chk("hold_f2", f2, held_f2);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic launch(input logic [11:0] t);
        @(negedge clk);
        start  = 1'b1;
        target = t;
        @(posedge clk);
        #1;
        start       = 1'b0;
        accept_edge = edge_cnt;
        exp_t       = int'(t);
        model(int'(t), exp_found, exp_f1, exp_f2, exp_lat);
        job_active  = 1'b1;
    endtask

    task automatic wait_done(output int lat, input bit chain, input logic [11:0] nt);
        lat = -1;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                lat = edge_cnt - accept_edge + 1;
                break;
            end
        end
        if (lat < 0) chk("done_timeout", 0, 1);
        if (chain) begin
            start  = 1'b1;
            target = nt;
        end
        @(posedge clk);
        #1;
        job_active = 1'b0;
    endtask

    task automatic run_job(input logic [11:0] t, input int l_found, input int l_f1,
                           input int l_f2, input int l_lat, input bit chain,
                           input logic [11:0] nt);
        int lat;
        launch(t);
        wait_done(lat, chain, nt);
        if (l_found >= 0) begin
            chk("lit_latency", lat, l_lat);
            chk("lit_found", found, l_found);
            chk("lit_f1", f1, l_f1);
            chk("lit_f2", f2, l_f2);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin : driver
        bit mf;
        int ma;
        int mb;
        int ml;
        int lat;

        rst_n  = 1'b0;
        start  = 1'b0;
        target = '0;

        // model pinned against hand-computed values
        model(143, mf, ma, mb, ml);
        chk("model_143_f1", ma, 11);
        chk("model_143_f2", mb, 13);
        chk("model_143_lat", ml, 141);
        model(3969, mf, ma, mb, ml);
        chk("model_3969_f1", ma, 63);
        chk("model_4095_found", 0, 0 + (mf ? 0 : 0));
        model(4095, mf, ma, mb, ml);
        chk("model_4095_fnd", mf, 0);
        chk("model_4095_lat", ml, 869);

        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_found", found, 0);
        chk("reset_f1", f1, 0);
        chk("reset_f2", f2, 0);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);

        run_job(12'd4,    1,  2,  2,  15, 0, 12'd0);
        run_job(12'd143,  1, 11, 13, 141, 0, 12'd0);
        run_job(12'd3969, 1, 63, 63, 869, 0, 12'd0);
        run_job(12'd4095, 0,  0,  0, 869, 0, 12'd0);
        run_job(12'd127,  0,  0,  0, 869, 0, 12'd0);
        // start raised during the done cycle must wait for the IDLE cycle
        run_job(12'd0,    0,  0,  0, 869, 1, 12'd6);
        run_job(12'd6,    1,  2,  3,  15, 0, 12'd0);

        // a second start in mid-search is dropped
        launch(12'd143);
        repeat (20) @(negedge clk);
        start  = 1'b1;
        target = 12'd9;
        @(negedge clk);
        start  = 1'b0;
        wait_done(lat, 0, 12'd0);
        chk("ign_latency", lat, 141);
        chk("ign_f1", f1, 11);
        chk("ign_f2", f2, 13);

        // asynchronous abort mid-search
        launch(12'd143);
        repeat (50) @(posedge clk);
        #2;
        chk("pre_abort_busy", busy, 1);
        rst_n      = 1'b0;
        job_active = 1'b0;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_found", found, 0);
        chk("abort_f1", f1, 0);
        chk("abort_f2", f2, 0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (20) @(posedge clk);
        run_job(12'd9, 1, 3, 3, 29, 0, 12'd0);

        for (int i = 0; i < 40; i++) begin
            run_job(12'($urandom_range(0, 300)), -1, 0, 0, 0, 0, 12'd0);
        end
        for (int i = 0; i < 20; i++) begin
            run_job(12'($urandom_range(0, 4095)), -1, 0, 0, 0, 0, 12'd0);
        end

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin : watchdog
        #3ms;
        chk("global_timeout", 0, 1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
